stim_pulse_monitor: RTL and testbench

Synthesizable receive-side monitor for the biphasic stimulus interface (`EN_ST`, `MAG_ST`, `ChSel_HS`, `ChSel_LS`) that drives the stimulator current DAC and channel switches. It decodes each anodic/cathodic pulse pair and measures phase widths and inter-pulse delay in clock cycles. It checks channel swap, magnitude consistency, electrode short and charge balance, then emits one pulse record per completed biphasic pulse. It sits beside the stimulator front end and feeds the readout/safety logic.

---
 rtl/stim_pkg.sv | 15 +
 rtl/stim_sat_counter.sv | 26 ++
 rtl/stim_pulse_monitor.sv | 190 +++++++++++++++++++
 tb/tb_stim_pulse_monitor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared types and constants for the biphasic stimulus pulse monitor.
package stim_pkg;

  localparam int unsigned CH_W  = 3;
  localparam int unsigned MAG_W = 5;
  localparam int unsigned ERR_W = 4;

  typedef enum logic [1:0] {IDLE, PH1, IPD, PH2} state_e;

  localparam int unsigned ERR_SHORT   = 0;
  localparam int unsigned ERR_SWAP    = 1;
  localparam int unsigned ERR_TIMEOUT = 2;
  localparam int unsigned ERR_GLITCH  = 3;

endpackage

// File: rtl/stim_sat_counter.sv
// Saturating up-counter with synchronous load-to-one and increment enable.
module stim_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_W'(1);
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stim_pulse_monitor.sv
// Decodes anodic/cathodic pulse pairs on the stimulus interface, measures phase
// and inter-pulse widths, flags protocol errors and emits one record per pair.
module stim_pulse_monitor
  import stim_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned IPD_MAX = 1000,
  parameter int unsigned BAL_TOL = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN_ST,
  input  logic [MAG_W-1:0] MAG_ST,
  input  logic [CH_W-1:0]  ChSel_HS,
  input  logic [CH_W-1:0]  ChSel_LS,
  input  logic             CLR_ERR,
  output logic             PULSE_VLD,
  output logic [CH_W-1:0]  CH_ANO,
  output logic [CH_W-1:0]  CH_CAT,
  output logic [MAG_W-1:0] MAG_OUT,
  output logic [CNT_W-1:0] W_ANO,
  output logic [CNT_W-1:0] W_CAT,
  output logic [CNT_W-1:0] IPD_W,
  output logic             BAL_OK,
  output logic [ERR_W-1:0] ERR,
  output logic [15:0]      PULSE_CNT
);

  logic             en_q, clr_q;
  logic [CH_W-1:0]  hs_q, ls_q, hs_prev_q, ls_prev_q;
  logic [MAG_W-1:0] mag_q, mag_prev_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_q       <= 1'b0;
      clr_q      <= 1'b0;
      hs_q       <= '0;
      ls_q       <= '0;
      mag_q      <= '0;
      hs_prev_q  <= '0;
      ls_prev_q  <= '0;
      mag_prev_q <= '0;
    end else begin
      en_q       <= EN_ST;
      clr_q      <= CLR_ERR;
      hs_q       <= ChSel_HS;
      ls_q       <= ChSel_LS;
      mag_q      <= MAG_ST;
      hs_prev_q  <= hs_q;
      ls_prev_q  <= ls_q;
      mag_prev_q <= mag_q;
    end
  end

  state_e           state_q;
  logic [CH_W-1:0]  a_q, b_q;
  logic [MAG_W-1:0] m_q;
  logic [CNT_W-1:0] w1_cnt, w2_cnt, g_cnt;

  logic w1_load, w1_inc, w2_load, w2_inc, g_load, g_inc;

  // FSM enters IDLE only with en_q low, so en_q high in IDLE is always a rise.
  assign w1_load = (state_q == IDLE) && en_q;
  assign w1_inc  = (state_q == PH1) && en_q;
  assign g_load  = (state_q == PH1) && !en_q;
  assign g_inc   = (state_q == IPD) && !en_q;
  assign w2_load = (state_q == IPD) && en_q;
  assign w2_inc  = (state_q == PH2) && en_q;

  stim_sat_counter #(.CNT_W(CNT_W)) u_w1_cnt (
    .clk   (CLK),
    .rst   (RST),
    .load  (w1_load),
    .inc   (w1_inc),
    .count (w1_cnt)
  );

  stim_sat_counter #(.CNT_W(CNT_W)) u_w2_cnt (
    .clk   (CLK),
    .rst   (RST),
    .load  (w2_load),
    .inc   (w2_inc),
    .count (w2_cnt)
  );

  stim_sat_counter #(.CNT_W(CNT_W)) u_g_cnt (
    .clk   (CLK),
    .rst   (RST),
    .load  (g_load),
    .inc   (g_inc),
    .count (g_cnt)
  );

  logic [31:0]      g_ext;
  logic             timeout, swap, short, glitch, bal;
  logic [CNT_W-1:0] w_diff;
  logic [ERR_W-1:0] err_set;

  assign g_ext   = 32'(g_cnt);
  // Abort on the low cycle that would bring the gap count up to IPD_MAX.
  assign timeout = g_inc && ((g_ext + 32'd1) >= IPD_MAX);
  assign swap    = w2_load && ((hs_q != b_q) || (ls_q != a_q) || (mag_q != m_q));
  assign short   = en_q && (hs_q == ls_q);
  assign glitch  = (w1_inc || w2_inc) &&
                   ((hs_q != hs_prev_q) || (ls_q != ls_prev_q) || (mag_q != mag_prev_q));
  assign w_diff  = (w1_cnt >= w2_cnt) ? (w1_cnt - w2_cnt) : (w2_cnt - w1_cnt);
  assign bal     = (32'(w_diff) <= BAL_TOL);

  always_comb begin
    err_set              = '0;
    err_set[ERR_SHORT]   = short;
    err_set[ERR_SWAP]    = swap;
    err_set[ERR_TIMEOUT] = timeout;
    err_set[ERR_GLITCH]  = glitch;
  end

  logic             vld_q, bal_q;
  logic [CH_W-1:0]  ch_ano_q, ch_cat_q;
  logic [MAG_W-1:0] mag_out_q;
  logic [CNT_W-1:0] w_ano_q, w_cat_q, ipd_q;
  logic [ERR_W-1:0] err_q;
  logic [15:0]      pcnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      vld_q     <= 1'b0;
      ch_ano_q  <= '0;
      ch_cat_q  <= '0;
      mag_out_q <= '0;
      w_ano_q   <= '0;
      w_cat_q   <= '0;
      ipd_q     <= '0;
      bal_q     <= 1'b0;
      err_q     <= '0;
      pcnt_q    <= '0;
    end else begin
      vld_q <= 1'b0;
      // Set wins over a simultaneous clear.
      err_q <= (err_q & ~{ERR_W{clr_q}}) | err_set;
      case (state_q)
        IDLE: begin
          if (en_q) begin
            a_q     <= hs_q;
            b_q     <= ls_q;
            m_q     <= mag_q;
            state_q <= PH1;
          end
        end
        PH1: begin
          if (!en_q) state_q <= IPD;
        end
        IPD: begin
          if (en_q)         state_q <= PH2;
          else if (timeout) state_q <= IDLE;
        end
        PH2: begin
          if (!en_q) begin
            vld_q     <= 1'b1;
            ch_ano_q  <= a_q;
            ch_cat_q  <= b_q;
            mag_out_q <= m_q;
            w_ano_q   <= w1_cnt;
            w_cat_q   <= w2_cnt;
            ipd_q     <= g_cnt;
            bal_q     <= bal;
            pcnt_q    <= pcnt_q + 16'd1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PULSE_VLD = vld_q;
  assign CH_ANO    = ch_ano_q;
  assign CH_CAT    = ch_cat_q;
  assign MAG_OUT   = mag_out_q;
  assign W_ANO     = w_ano_q;
  assign W_CAT     = w_cat_q;
  assign IPD_W     = ipd_q;
  assign BAL_OK    = bal_q;
  assign ERR       = err_q;
  assign PULSE_CNT = pcnt_q;

endmodule

// File: tb/tb_stim_pulse_monitor.sv
// Directed bench for stim_pulse_monitor with a scoreboard of expected pulse records.
module tb_stim_pulse_monitor;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN_ST = 1'b0;
  logic [4:0]  MAG_ST = '0;
  logic [2:0]  ChSel_HS = '0;
  logic [2:0]  ChSel_LS = '0;
  logic        CLR_ERR = 1'b0;

  logic        vld, bal;
  logic [2:0]  ch_ano, ch_cat;
  logic [4:0]  mag_out;
  logic [15:0] w_ano, w_cat, ipd_w, pcnt;
  logic [3:0]  err;

  logic        vld8, bal8;
  logic [2:0]  ch_ano8, ch_cat8;
  logic [4:0]  mag_out8;
  logic [7:0]  w_ano8, w_cat8, ipd_w8;
  logic [15:0] pcnt8;
  logic [3:0]  err8;

  always #5 CLK = ~CLK;

  stim_pulse_monitor #(.CNT_W(16), .IPD_MAX(1000), .BAL_TOL(2)) dut (
    .CLK(CLK), .RST(RST), .EN_ST(EN_ST), .MAG_ST(MAG_ST), .ChSel_HS(ChSel_HS),
    .ChSel_LS(ChSel_LS), .CLR_ERR(CLR_ERR), .PULSE_VLD(vld), .CH_ANO(ch_ano),
    .CH_CAT(ch_cat), .MAG_OUT(mag_out), .W_ANO(w_ano), .W_CAT(w_cat), .IPD_W(ipd_w),
    .BAL_OK(bal), .ERR(err), .PULSE_CNT(pcnt)
  );

  stim_pulse_monitor #(.CNT_W(8), .IPD_MAX(1000), .BAL_TOL(2)) dut8 (
    .CLK(CLK), .RST(RST), .EN_ST(EN_ST), .MAG_ST(MAG_ST), .ChSel_HS(ChSel_HS),
    .ChSel_LS(ChSel_LS), .CLR_ERR(CLR_ERR), .PULSE_VLD(vld8), .CH_ANO(ch_ano8),
    .CH_CAT(ch_cat8), .MAG_OUT(mag_out8), .W_ANO(w_ano8), .W_CAT(w_cat8), .IPD_W(ipd_w8),
    .BAL_OK(bal8), .ERR(err8), .PULSE_CNT(pcnt8)
  );

  typedef struct {
    logic [2:0]  ch_ano;
    logic [2:0]  ch_cat;
    logic [4:0]  mag;
    logic [15:0] w_ano;
    logic [15:0] w_cat;
    logic [15:0] ipd;
    logic        bal;
    logic [3:0]  err;
    logic [15:0] pcnt;
  } rec_t;

  rec_t sb[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;
  int   vld_seen = 0;
  int   exp_pcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    rec_t r;
    if (!RST && vld) begin
      vld_seen++;
      check("vld_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        check("ch_ano", 32'(ch_ano), 32'(r.ch_ano));
        check("ch_cat", 32'(ch_cat), 32'(r.ch_cat));
        check("mag_out", 32'(mag_out), 32'(r.mag));
        check("w_ano", 32'(w_ano), 32'(r.w_ano));
        check("w_cat", 32'(w_cat), 32'(r.w_cat));
        check("ipd_w", 32'(ipd_w), 32'(r.ipd));
        check("bal_ok", 32'(bal), 32'(r.bal));
        check("err", 32'(err), 32'(r.err));
        check("pulse_cnt", 32'(pcnt), 32'(r.pcnt));
      end
    end
  end

  task automatic phase(input logic en, input logic [2:0] hs, input logic [2:0] ls,
                       input logic [4:0] mag, input int n);
    EN_ST = en;
    ChSel_HS = hs;
    ChSel_LS = ls;
    MAG_ST = mag;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_rec(input logic [2:0] a, input logic [2:0] b, input logic [4:0] m,
                          input int w1, input int gap, input int w2, input logic [3:0] e);
    rec_t r;
    int d;
    exp_pcnt++;
    d = (w1 > w2) ? (w1 - w2) : (w2 - w1);
    r.ch_ano = a;
    r.ch_cat = b;
    r.mag    = m;
    r.w_ano  = 16'(w1);
    r.w_cat  = 16'(w2);
    r.ipd    = 16'(gap);
    r.bal    = (d <= 2);
    r.err    = e;
    r.pcnt   = 16'(exp_pcnt);
    sb.push_back(r);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(posedge CLK);
      k++;
    end
    #1;
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  // Channels a/b for phase 1, h2/l2 for phase 2 (normally h2=b, l2=a).
  task automatic pair(input logic [2:0] a, input logic [2:0] b, input logic [2:0] h2,
                      input logic [2:0] l2, input logic [4:0] m, input int w1,
                      input int gap, input int w2, input logic [3:0] e, input string tag);
    push_rec(a, b, m, w1, gap, w2, e);
    phase(1'b1, a, b, m, w1);
    phase(1'b0, h2, l2, m, gap);
    phase(1'b1, h2, l2, m, w2);
    phase(1'b0, h2, l2, m, 5);
    drain(tag);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_vld"}, 32'(vld), 32'd0);
    check({tag, "_ch_ano"}, 32'(ch_ano), 32'd0);
    check({tag, "_ch_cat"}, 32'(ch_cat), 32'd0);
    check({tag, "_mag"}, 32'(mag_out), 32'd0);
    check({tag, "_w_ano"}, 32'(w_ano), 32'd0);
    check({tag, "_w_cat"}, 32'(w_cat), 32'd0);
    check({tag, "_ipd"}, 32'(ipd_w), 32'd0);
    check({tag, "_bal"}, 32'(bal), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_pcnt"}, 32'(pcnt), 32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN_ST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_pcnt = 0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin : stimulus
    int v0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_idle_outputs("reset");

    pair(3'd1, 3'd2, 3'd2, 3'd1, 5'd31, 150, 10, 150, 4'b0000, "nominal");
    pair(3'd3, 3'd5, 3'd5, 3'd3, 5'd7, 150, 4, 147, 4'b0000, "imbal_3");
    pair(3'd3, 3'd5, 3'd5, 3'd3, 5'd7, 150, 1, 148, 4'b0000, "imbal_2");

    // Second phase drives HS=LS=2: swap and short, record still emitted.
    pair(3'd1, 3'd2, 3'd2, 3'd2, 5'd9, 20, 4, 20, 4'b0011, "swap_short");
    CLR_ERR = 1'b1;
    @(posedge CLK);
    #1;
    CLR_ERR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("clr_err", 32'(err), 32'd0);

    v0 = vld_seen;
    phase(1'b1, 3'd1, 3'd2, 5'd5, 50);
    phase(1'b0, 3'd2, 3'd1, 5'd5, 1000);
    phase(1'b0, 3'd2, 3'd1, 5'd5, 5);
    check("timeout_err", 32'(err), 32'b0100);
    check("timeout_no_vld", 32'(vld_seen - v0), 32'd0);
    // Longest gap that still completes.
    pair(3'd4, 3'd6, 3'd6, 3'd4, 5'd12, 30, 999, 30, 4'b0100, "ipd_999");

    do_reset();
    push_rec(3'd1, 3'd2, 5'd3, 300, 10, 300, 4'b1000);
    phase(1'b1, 3'd1, 3'd2, 5'd3, 100);
    phase(1'b1, 3'd3, 3'd2, 5'd3, 100);
    phase(1'b1, 3'd1, 3'd2, 5'd3, 100);
    phase(1'b0, 3'd2, 3'd1, 5'd3, 10);
    phase(1'b1, 3'd2, 3'd1, 5'd3, 300);
    phase(1'b0, 3'd2, 3'd1, 5'd3, 5);
    drain("glitch");
    check("sat_w_ano8", 32'(w_ano8), 32'd255);
    check("sat_w_cat8", 32'(w_cat8), 32'd255);
    check("glitch_err8", 32'(err8[3]), 32'd1);
    check("sat_ch_ano8", 32'(ch_ano8), 32'd1);

    v0 = vld_seen;
    phase(1'b1, 3'd1, 3'd2, 5'd4, 20);
    phase(1'b0, 3'd2, 3'd1, 5'd4, 5);
    phase(1'b1, 3'd2, 3'd1, 5'd4, 10);
    RST = 1'b1;
    EN_ST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    exp_pcnt = 0;
    repeat (10) @(posedge CLK);
    #1;
    check("rst_no_vld", 32'(vld_seen - v0), 32'd0);
    check_idle_outputs("rst_mid");
    pair(3'd2, 3'd1, 3'd1, 3'd2, 5'd17, 20, 5, 20, 4'b0000, "after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
